wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq.sv | 128 ++++++++++++
 tb/tb_wide_add_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Multi-byte add/subtract sequencer: walks operand limbs LSB-first through an
// external 8-bit ALU, chaining the carry between limbs.
module wide_add_seq #(
  parameter int BYTES = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Sub,
  input  logic [BYTES*8-1:0] OperandA,
  input  logic [BYTES*8-1:0] OperandB,
  output logic [7:0]         AluInputA,
  output logic [7:0]         AluInputB,
  output logic [3:0]         AluOP,
  output logic               AluOverflowIn,
  input  logic [7:0]         AluOut,
  input  logic               AluOverflowOut,
  output logic [BYTES*8-1:0] Result,
  output logic               CarryOut,
  output logic               Zero,
  output logic               Busy,
  output logic               Done
);

  localparam int W     = BYTES * 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic [7:0]       limb_a, limb_b;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  // Operand latches are only meaningful after a Start, so they carry no reset.
  always_ff @(posedge Clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
  end

  always_comb begin
    limb_a = 8'h00;
    limb_b = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        limb_a = a_q[i*8 +: 8];
        limb_b = b_q[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    c_d           = c_q;
    result_d      = result_q;
    carry_d       = carry_q;
    a_d           = a_q;
    b_d           = b_q;
    sub_d         = sub_q;
    AluInputA     = 8'h00;
    AluInputB     = 8'h00;
    AluOP         = 4'b0000;
    AluOverflowIn = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d      = OperandA;
          b_d      = OperandB;
          sub_d    = Sub;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Subtraction is A + ~B + 1: the +1 enters as carry-in of limb 0.
        AluInputA     = limb_a;
        AluInputB     = sub_q ? ~limb_b : limb_b;
        AluOverflowIn = (idx_q == '0) ? sub_q : c_q;
        for (int i = 0; i < BYTES; i++) begin
          if (idx_q == IDX_W'(i)) result_d[i*8 +: 8] = AluOut;
        end
        c_d = AluOverflowOut;
        if (idx_q == LAST_IDX) begin
          carry_d = AluOverflowOut;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Result   = result_q;
  assign CarryOut = carry_q;
  assign Zero     = (result_q == '0);
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq (BYTES=2) with a behavioural ALU and an
// occupancy/arithmetic reference model checked every cycle.
module tb_wide_add_seq;
  localparam int BYTES = 2;
  localparam int W     = BYTES * 8;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic         Sub = 1'b0;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] OperandB = '0;
  logic [7:0]   AluInputA, AluInputB, AluOut;
  logic [3:0]   AluOP;
  logic         AluOverflowIn, AluOverflowOut;
  logic [W-1:0] Result;
  logic         CarryOut, Zero, Busy, Done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  wide_add_seq #(.BYTES(BYTES)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Sub(Sub),
    .OperandA(OperandA), .OperandB(OperandB),
    .AluInputA(AluInputA), .AluInputB(AluInputB), .AluOP(AluOP),
    .AluOverflowIn(AluOverflowIn), .AluOut(AluOut), .AluOverflowOut(AluOverflowOut),
    .Result(Result), .CarryOut(CarryOut), .Zero(Zero), .Busy(Busy), .Done(Done)
  );

  // Team ALU: OP 0 is an 8-bit add with carry in/out.
  assign {AluOverflowOut, AluOut} = (AluOP == 4'd0) ?
    ({1'b0, AluInputA} + {1'b0, AluInputB} + {8'd0, AluOverflowIn}) : 9'd0;

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an op occupies BYTES+1 cycles; result is plain W-bit arithmetic.
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (Start) begin
        logic [W:0] full;
        full = Sub ? ({1'b0, OperandA} + {1'b0, ~OperandB} + (W+1)'(1))
                   : ({1'b0, OperandA} + {1'b0, OperandB});
        m_res <= full[W-1:0];
        m_c   <= full[W];
        m_cnt <= 1;
      end
    end else begin
      m_cnt <= (m_cnt == BYTES + 1) ? 0 : m_cnt + 1;
    end
  end

  always @(negedge Clk) begin
    if (Reset) begin
      chk("busy", Busy, m_cnt != 0);
      chk("done", Done, m_cnt == BYTES + 1);
      if (Done) done_cnt++;
      if (m_cnt == BYTES + 1) begin
        chk("model_result", Result, m_res);
        chk("model_carry", CarryOut, m_c);
        chk("model_zero", Zero, m_res == '0);
      end
      if (m_cnt == 0 || m_cnt == BYTES + 1)
        chk("alu_idle", {AluInputA, AluInputB, AluOP, AluOverflowIn}, 32'd0);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] er, input logic ec, input logic ez,
                        input string nm);
    int cyc;
    bit got;
    @(negedge Clk);
    Start = 1'b1; OperandA = a; OperandB = b; Sub = s;
    @(posedge Clk);
    #1 Start = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin
      @(negedge Clk);
      cyc++;
      if (Done) got = 1;
    end
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_latency"}, cyc, BYTES + 1);
    chk({nm, "_result"}, Result, er);
    chk({nm, "_carry"}, CarryOut, ec);
    chk({nm, "_zero"}, Zero, ez);
    @(negedge Clk);
  endtask

  initial begin
    int d0;
    #2;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_zero", Zero, 1);
    chk("rst_result", Result, 0);
    chk("rst_carry", CarryOut, 0);
    chk("rst_alu", {AluInputA, AluInputB, AluOP, AluOverflowIn}, 0);
    @(negedge Clk);
    Reset = 1'b1;

    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "add_ff_1");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, "add_wrap");
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1, "sub_eq");
    run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
    run_op(16'hA5C3, 16'h5A3D, 1'b0, 16'h0000, 1'b1, 1'b1, "add_chain");
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, "sub_mid");

    // Start pulsed with new operands while RUN is in progress.
    d0 = done_cnt;
    @(negedge Clk);
    Start = 1'b1; OperandA = 16'h0102; OperandB = 16'h0304; Sub = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    OperandA = 16'hFFFF; OperandB = 16'hFFFF; Sub = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    chk("ignore_done", Done, 1);
    chk("ignore_result", Result, 16'h0406);
    repeat (4) @(negedge Clk);
    chk("ignore_one_done", done_cnt - d0, 1);

    // Reset asserted mid-RUN at limb 1.
    d0 = done_cnt;
    @(negedge Clk);
    Start = 1'b1; OperandA = 16'h1111; OperandB = 16'h2222; Sub = 1'b0;
    @(posedge Clk);
    #1 Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("midrst_busy", Busy, 0);
    chk("midrst_result", Result, 0);
    chk("midrst_done", Done, 0);
    chk("midrst_zero", Zero, 1);
    chk("midrst_alu", {AluInputA, AluInputB, AluOP, AluOverflowIn}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "after_rst");

    // Start held high: back-to-back ops, one accept per IDLE visit.
    d0 = done_cnt;
    @(negedge Clk);
    Start = 1'b1; OperandA = 16'h0005; OperandB = 16'h0003; Sub = 1'b1;
    repeat (12) @(negedge Clk);
    Start = 1'b0;
    repeat (6) @(negedge Clk);
    chk("held_done_count", done_cnt - d0, 3);
    chk("held_result", Result, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule
